multicycle_core: RTL
====================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register/data width (>=16).
REQ-002 SHALL have parameter PC_W, default 16, byte-address width of PC, imem_addr and dmem_addr.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  PC_W  fetch byte address (= pc).
REQ-008 imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
REQ-009 imem_rdata  in  16  instruction word.
REQ-010 dmem_req  out  1  data access request.
REQ-011 dmem_we  out  1  1=store, 0=load; valid while dmem_req=1.
REQ-012 dmem_addr  out  PC_W  data byte address.
REQ-013 dmem_wdata  out  DATA_W  store data.
REQ-014 dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads.
REQ-015 dmem_rdata  in  DATA_W  load data.
REQ-016 state  out  3  current FSM state encoding.
REQ-017 pc  out  PC_W  architectural PC.
REQ-018 retire  out  1  one-cycle pulse when an instruction completes.
REQ-019 halted  out  1  high while in HALT.

Function
REQ-020 SHALL decode: op=[15:12], ra=[11:9], rb=[8:6], rc=[5:3], imm6=[5:0], imm9=[8:0]; immediates sign-extended to DATA_W (PC_W for PC arithmetic).
REQ-021 SHALL implement: 0000 ADD rc=ra+rb; 0010 NAND rc=~(ra&rb); 1010 LW ra=M[rb+imm6]; 1001 SW M[rb+imm6]=ra; 1011 BEQ if ra==rb pc=pc+2*imm6; 1101 JAL ra=pc+2, pc=pc+2*imm9; 1111 HALT; any other opcode = NOP.
REQ-022 SHALL hold 8 registers R0..R7 of DATA_W bits, all writable; arithmetic modulo 2^DATA_W, carry discarded.
REQ-023 SHALL use FSM states FETCH=0, EXEC=1, MEM=2, WB=3, HALT=4.
REQ-024 FETCH: imem_req=1 until imem_ack; on ack latch instruction and read ra/rb operands, go EXEC.
REQ-025 EXEC: compute result/address/compare; LW/SW -> MEM; ADD/NAND/JAL -> WB; BEQ/NOP -> FETCH with PC updated; HALT -> HALT.
REQ-026 MEM: dmem_req=1 with stable addr/we/wdata until dmem_ack; load data latched on ack; LW -> WB, SW -> FETCH.
REQ-027 WB: write destination (rc for ADD/NAND, ra for LW/JAL), update PC, go FETCH.
REQ-028 Non-branch PC update SHALL be pc+2; taken BEQ/JAL target replaces it; PC wraps modulo 2^PC_W.
REQ-029 Zero-wait latency SHALL be: BEQ/NOP 2 cycles, ADD/NAND/JAL/SW 3, LW 4; each ack-wait cycle adds one.
REQ-030 retire SHALL pulse on the cycle leaving EXEC to FETCH, MEM to FETCH, or WB, and on entering HALT.
REQ-031 ack SHALL be ignored when the matching req is low; req asserted in cycle N may be acked in cycle N.
REQ-032 JAL with ra = writes pc+2 of the JAL itself; LW with ra=rb uses pre-write rb for the address.
REQ-033 HALT SHALL be left only by reset; no requests issued while halted.

Reset
REQ-034 reset=1 at a rising edge SHALL set state=FETCH, pc=RESET_PC, R0..R7=0, imem_req/dmem_req/retire/halted=0 on the next cycle; imem_req=1 from the first cycle after reset deasserts.
REQ-035 reset SHALL override any state, including mid-access; an ack arriving in the reset cycle SHALL be discarded.

Verification
REQ-036 Reset, zero-wait memory, ADD R3=R1+R2 with R1=11,R2=22 -> R3=33 after 3 cycles, pc=2, one retire pulse.
REQ-037 LW with rb=4, imm6=-2 (0x3E), dmem_ack delayed 3 cycles, rdata=0xBEEF -> dmem_addr=2, dmem_req held 4 cycles, ra=0xBEEF, total 7 cycles.
REQ-038 BEQ at pc=0x10, ra==rb, imm6=-4 -> pc=0x08 after 2 cycles; ra!=rb -> pc=0x12.
REQ-039 JAL at pc=0xFFFE (PC_W=16), imm9=1 -> ra=0x0000, pc=0x0000 (wrap).
REQ-040 NAND with 0xFFFF,0x00FF -> rc=0xFF00; then HALT -> halted=1, no req for 10 cycles; reset -> pc=RESET_PC, fetch resumes.
REQ-041 Assert reset during MEM of SW with dmem_ack in same cycle -> no register change, state=FETCH, pc=RESET_PC.

Source files
------------

// File: rtl/multicycle_core.sv
// Multicycle 16-bit-instruction core: FETCH/EXEC/MEM/WB/HALT FSM
// with eight general registers and req/ack instruction and data ports.
module multicycle_core #(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [PC_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [2:0]        state,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b1010;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_JAL  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t            st;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic [PC_W-1:0]   npc_q;
    logic [DATA_W-1:0] rf [8];

    logic [3:0]        op;
    logic [2:0]        ra;
    logic [2:0]        rb;
    logic [2:0]        rc;
    logic [2:0]        dst;
    logic [DATA_W-1:0] imm6;
    logic [DATA_W-1:0] ea;
    logic [PC_W-1:0]   off6;
    logic [PC_W-1:0]   off9;
    logic [PC_W-1:0]   pc2;

    assign op   = ir[15:12];
    assign ra   = ir[11:9];
    assign rb   = ir[8:6];
    assign rc   = ir[5:3];
    assign dst  = (op == OP_ADD || op == OP_NAND) ? rc : ra;
    assign imm6 = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    assign ea   = b_q + imm6;
    // branch offsets are in halfwords, so shift left by one
    assign off6 = {{(PC_W-7){ir[5]}}, ir[5:0], 1'b0};
    assign off9 = {{(PC_W-10){ir[8]}}, ir[8:0], 1'b0};
    assign pc2  = pc + PC_W'(2);

    assign imem_addr = pc;
    assign state     = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= FETCH;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            ir         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            npc_q      <= '0;
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else begin
            retire <= 1'b0;
            unique case (st)
                FETCH: begin
                    imem_req <= 1'b1;
                    if (imem_req && imem_ack) begin
                        imem_req <= 1'b0;
                        ir       <= imem_rdata;
                        a_q      <= rf[imem_rdata[11:9]];
                        b_q      <= rf[imem_rdata[8:6]];
                        st       <= EXEC;
                    end
                end
                EXEC: begin
                    case (op)
                        OP_ADD: begin
                            res_q <= a_q + b_q;
                            npc_q <= pc2;
                            st    <= WB;
                        end
                        OP_NAND: begin
                            res_q <= ~(a_q & b_q);
                            npc_q <= pc2;
                            st    <= WB;
                        end
                        OP_LW, OP_SW: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_SW);
                            dmem_addr  <= PC_W'(ea);
                            dmem_wdata <= a_q;
                            st         <= MEM;
                        end
                        OP_BEQ: begin
                            pc       <= (a_q == b_q) ? pc + off6 : pc2;
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            st       <= FETCH;
                        end
                        OP_JAL: begin
                            res_q <= DATA_W'(pc2);
                            npc_q <= pc + off9;
                            st    <= WB;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            retire <= 1'b1;
                            st     <= HALT;
                        end
                        default: begin
                            pc       <= pc2;
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            st       <= FETCH;
                        end
                    endcase
                end
                MEM: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            pc       <= pc2;
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            st       <= FETCH;
                        end else begin
                            res_q <= dmem_rdata;
                            npc_q <= pc2;
                            st    <= WB;
                        end
                    end
                end
                WB: begin
                    rf[dst]  <= res_q;
                    pc       <= npc_q;
                    retire   <= 1'b1;
                    imem_req <= 1'b1;
                    st       <= FETCH;
                end
                HALT: begin
                    st <= HALT;
                end
                default: begin
                    st <= FETCH;
                end
            endcase
        end
    end

endmodule
